register_read_unit: RTL
=======================

# register_read_unit

Read-side companion to the register write-enable decoder in the 4-entry LALU register file. It accepts operand-fetch requests on a valid/ready handshake and reads two source registers. It forwards any same-cycle write-back and tracks pending writers in a 4-bit scoreboard, stalling on read-after-write and write-after-write hazards. It presents registered operands to the execute stage one cycle later.

## Interface
- DATA_WIDTH, 8, width of each register and operand
- logisimClockTree0  in  5  clock tree bus; all state updates on the rising edge of bit [4]
- reset  in  1  synchronous, active-high
- reg0Q, reg1Q, reg2Q, reg3Q  in  DATA_WIDTH each  current register contents
- regWrite  in  1  write-back strobe, the same net that drives the write-enable decoder
- Rd  in  2  write-back destination index
- wbData  in  DATA_WIDTH  write-back data, committed to the register at this clock edge
- issueValid  in  1  fetch request valid
- issueRs, issueRt  in  2 each  source register indices
- issueRd  in  2  destination of the issuing instruction
- issueWrites  in  1  issuing instruction will write issueRd
- issueReady  out  1  request accepted this cycle when high with issueValid
- opValid  out  1  operand bundle valid
- opA, opB  out  DATA_WIDTH each  operands for Rs and Rt
- opRd  out  2  registered issueRd
- opWrites  out  1  registered issueWrites
- opReady  in  1  execute stage accepts the bundle
- busy  out  4  scoreboard; bit n set means register n has a pending writer

## Operation
- Forwarding: a source value is regNQ at its index. If regWrite is high and Rd equals that index, the value is wbData instead.
- Source hazard (per source): busy[idx] is set and the forward condition for idx is false.
- WAW hazard: issueWrites is high, busy[issueRd] is set, and the forward condition for issueRd is false.
- issueReady = no source hazard, no WAW hazard, and (opValid low or opReady high). It must not depend on issueValid.
- fire = issueValid and issueReady.
- On fire: opA/opB capture the forwarded values, opRd/opWrites capture the issue fields, and opValid is set.
- When opValid is high and opReady is high without a fire, opValid clears. The data registers hold their last value.
- When opValid is high and opReady is low, all op* outputs stay stable.
- Scoreboard set: on fire with issueWrites, set busy[issueRd].
- Scoreboard clear: when regWrite is high, clear busy[Rd].
- If a set and a clear hit the same bit in the same cycle, set wins.
- A regWrite to a non-busy register is legal. It only forwards; the scoreboard is unchanged.
- Reset: busy=0, opValid=0, opA=opB=0, opRd=0, opWrites=0. In-flight requests are discarded. regWrite during reset has no effect on state.

## Timing
- Issue-to-operand latency is 1 cycle. Throughput is 1 request per cycle when there is no hazard and opReady is held high.
- issueReady, and the forward and hazard terms behind it, are combinational from busy, the issue fields, regWrite/Rd, opValid and opReady.
- The scoreboard update is visible in busy one cycle after fire or write-back.
- A stalled request resolves in the same cycle that the matching regWrite appears, through forwarding, with no extra bubble.
- Reset is sampled only on the clock edge and overrides fire and regWrite in that cycle.

## Structure
- Shared package lalu_pkg holds:
  - DATA_WIDTH default
  - REG_ADDR_W = 2
  - NUM_REGS = 4
  - the register index type
- Sub-module operand_forward_mux, instantiated twice (Rs, Rt):
  - inputs: index, reg0Q..reg3Q, regWrite, Rd, wbData
  - outputs: the forwarded value and the hazard bit, given busy
- The top level holds the scoreboard, the output register stage and the handshake logic.

## Test plan
- Reset then idle: busy=0000, opValid=0, all op* outputs 0. Issue Rs=1, Rt=2 with reg1Q=0x11, reg2Q=0x22 and opReady=1 → next cycle opValid=1, opA=0x11, opB=0x22.
- RAW stall: issue Rd=3 with issueWrites=1 → busy=1000. Then issue Rs=3 → issueReady=0 for 3 cycles. Then regWrite=1, Rd=3, wbData=0x5A → accepted that cycle, opA=0x5A next cycle, busy=0000.
- Same-cycle forwarding without pending: reg0Q=0x01, regWrite=1, Rd=0, wbData=0xF0, issue Rs=0 → opA=0xF0.
- Backpressure: opValid=1 and opReady=0 for 4 cycles with issueValid held → issueReady=0 and op* stable. When opReady=1 → the new bundle loads in the same cycle.
- WAW and set-wins: busy[2]=1, then regWrite Rd=2 and issue with issueWrites=1, Rd=2 in the same cycle → accepted, busy[2] stays 1.
- Reset mid-stall: busy=0110 with opValid=1, assert reset for 1 cycle → busy=0000, opValid=0, and the next request is accepted immediately.

Source files
------------

// File: rtl/lalu_pkg.sv
// Shared LALU register-file definitions used by the read-side operand fetch logic.
package lalu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int REG_ADDR_W         = 2;
  localparam int NUM_REGS           = 4;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // True when the write-back in this cycle targets the given register.
  function automatic logic wb_hits(input logic reg_write, input reg_idx_t rd, input reg_idx_t idx);
    return reg_write && (rd == idx);
  endfunction

endpackage

// File: rtl/register_read_unit_if.sv
// Operand-fetch bus: register contents, write-back, issue handshake and operand bundle.
interface register_read_unit_if
  import lalu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] reg0Q;
  logic [DATA_WIDTH-1:0] reg1Q;
  logic [DATA_WIDTH-1:0] reg2Q;
  logic [DATA_WIDTH-1:0] reg3Q;

  logic                  regWrite;
  reg_idx_t              Rd;
  logic [DATA_WIDTH-1:0] wbData;

  logic                  issueValid;
  reg_idx_t              issueRs;
  reg_idx_t              issueRt;
  reg_idx_t              issueRd;
  logic                  issueWrites;
  logic                  issueReady;

  logic                  opValid;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  reg_idx_t              opRd;
  logic                  opWrites;
  logic                  opReady;

  logic [NUM_REGS-1:0]   busy;

  modport master (
    output reg0Q, reg1Q, reg2Q, reg3Q,
    output regWrite, Rd, wbData,
    output issueValid, issueRs, issueRt, issueRd, issueWrites,
    output opReady,
    input  issueReady,
    input  opValid, opA, opB, opRd, opWrites,
    input  busy
  );

  modport slave (
    input  reg0Q, reg1Q, reg2Q, reg3Q,
    input  regWrite, Rd, wbData,
    input  issueValid, issueRs, issueRt, issueRd, issueWrites,
    input  opReady,
    output issueReady,
    output opValid, opA, opB, opRd, opWrites,
    output busy
  );

endinterface

// File: rtl/operand_forward_mux.sv
// Selects one source operand, bypassing a same-cycle write-back, and flags a pending writer.
module operand_forward_mux
  import lalu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  reg_idx_t              idx,
  input  logic [DATA_WIDTH-1:0] reg0Q,
  input  logic [DATA_WIDTH-1:0] reg1Q,
  input  logic [DATA_WIDTH-1:0] reg2Q,
  input  logic [DATA_WIDTH-1:0] reg3Q,
  input  logic                  regWrite,
  input  reg_idx_t              Rd,
  input  logic [DATA_WIDTH-1:0] wbData,
  input  logic [NUM_REGS-1:0]   busy,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  hazard
);

  logic [DATA_WIDTH-1:0] reg_sel;
  logic                  wb_hit;

  always_comb begin
    reg_sel = reg0Q;
    case (idx)
      2'd0:    reg_sel = reg0Q;
      2'd1:    reg_sel = reg1Q;
      2'd2:    reg_sel = reg2Q;
      default: reg_sel = reg3Q;
    endcase
  end

  assign wb_hit = wb_hits(regWrite, Rd, idx);
  assign value  = wb_hit ? wbData : reg_sel;
  // A pending writer that is retiring right now is not a hazard: its data is forwarded.
  assign hazard = busy[idx] & ~wb_hit;

endmodule

// File: rtl/register_read_unit.sv
// Operand fetch for the 4-entry LALU register file: scoreboard, hazard stall and
// a single registered operand stage toward execute.
module register_read_unit
  import lalu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [4:0]             logisimClockTree0,
  input  logic                   reset,
  register_read_unit_if.slave    bus
);

  logic clk;
  logic unused_clk_taps;

  assign clk             = logisimClockTree0[4];
  assign unused_clk_taps = ^logisimClockTree0[3:0];

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_set;
  logic [NUM_REGS-1:0]   busy_clr;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  reg_idx_t              op_rd_q;
  logic                  op_writes_q;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  hazard_waw;
  logic                  stage_free;
  logic                  issue_ready;
  logic                  fire;

  operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs (
    .idx      (bus.issueRs),
    .reg0Q    (bus.reg0Q),
    .reg1Q    (bus.reg1Q),
    .reg2Q    (bus.reg2Q),
    .reg3Q    (bus.reg3Q),
    .regWrite (bus.regWrite),
    .Rd       (bus.Rd),
    .wbData   (bus.wbData),
    .busy     (busy_q),
    .value    (fwd_a),
    .hazard   (hazard_a)
  );

  operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rt (
    .idx      (bus.issueRt),
    .reg0Q    (bus.reg0Q),
    .reg1Q    (bus.reg1Q),
    .reg2Q    (bus.reg2Q),
    .reg3Q    (bus.reg3Q),
    .regWrite (bus.regWrite),
    .Rd       (bus.Rd),
    .wbData   (bus.wbData),
    .busy     (busy_q),
    .value    (fwd_b),
    .hazard   (hazard_b)
  );

  assign hazard_waw  = bus.issueWrites & busy_q[bus.issueRd]
                       & ~wb_hits(bus.regWrite, bus.Rd, bus.issueRd);
  assign stage_free  = ~op_valid_q | bus.opReady;
  assign issue_ready = ~hazard_a & ~hazard_b & ~hazard_waw & stage_free;
  assign fire        = bus.issueValid & issue_ready;

  // Set is applied after clear so a new writer claiming a retiring register keeps it busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (bus.regWrite) begin
      busy_clr[bus.Rd] = 1'b1;
    end
    if (fire && bus.issueWrites) begin
      busy_set[bus.issueRd] = 1'b1;
    end
    busy_next = (busy_q & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
      op_writes_q <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (fire) begin
        op_valid_q  <= 1'b1;
        op_a_q      <= fwd_a;
        op_b_q      <= fwd_b;
        op_rd_q     <= bus.issueRd;
        op_writes_q <= bus.issueWrites;
      end else if (op_valid_q && bus.opReady) begin
        op_valid_q <= 1'b0;
      end
    end
  end

  assign bus.issueReady = issue_ready;
  assign bus.opValid    = op_valid_q;
  assign bus.opA        = op_a_q;
  assign bus.opB        = op_b_q;
  assign bus.opRd       = op_rd_q;
  assign bus.opWrites   = op_writes_q;
  assign bus.busy       = busy_q;

endmodule
